uart_tx_arbiter: RTL and testbench

Shares a single uart_tx transmitter between NUM_REQ byte-stream requesters.
- Each requester presents packets: a sequence of bytes, the final byte flagged by req_last.
- Round-robin arbitration; the grant is held for a whole packet, so packets never interleave on the serial line.
- Sits between the host-side message sources and uart_tx. It sequences uart_tx's wrEn/busy handshake byte by byte and flags a transmitter that fails to respond.

---
 rtl/uart_tx_arbiter.sv | 143 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_tx between NUM_REQ
// packet-oriented byte sources. A grant covers a whole packet; each byte
// is handed over with a single wrEn pulse, and the arbiter then follows
// uart_tx busy through its rise and fall before the next byte.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int BUSY_TIMEOUT = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   tx_wr_en,
  output logic [7:0]             tx_din,
  input  logic                   tx_busy,
  output logic                   active,
  output logic                   timeout_err
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int TMR_W = $clog2(BUSY_TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SEND    = 2'd1,
    S_WAIT_HI = 2'd2,
    S_WAIT_LO = 2'd3
  } state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_sel;
  logic [IDX_W-1:0] r_rr_ptr;
  logic [TMR_W-1:0] r_timer;
  logic             r_last;

  logic             w_any;
  logic [IDX_W-1:0] w_sel;
  logic [IDX_W:0]   w_scan;
  logic [IDX_W-1:0] w_next_ptr;
  logic             w_byte_done;

  function automatic logic [NUM_REQ-1:0] f_onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Round-robin pick: first valid requester scanning upward from r_rr_ptr, with wrap.
  always_comb begin
    w_any  = 1'b0;
    w_sel  = '0;
    w_scan = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_scan = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
      if (w_scan >= (IDX_W+1)'(NUM_REQ)) begin
        w_scan = w_scan - (IDX_W+1)'(NUM_REQ);
      end
      if (!w_any && req_valid[w_scan[IDX_W-1:0]]) begin
        w_any = 1'b1;
        w_sel = w_scan[IDX_W-1:0];
      end
    end
  end

  // A byte finishes either when busy falls normally or when busy never rose in time.
  always_comb begin
    w_next_ptr  = (r_sel == IDX_W'(NUM_REQ - 1)) ? '0 : r_sel + 1'b1;
    w_byte_done = ((r_state == S_WAIT_HI) && !tx_busy && (r_timer == TMR_LAST)) ||
                  ((r_state == S_WAIT_LO) && !tx_busy);
  end

  // Arbitration / handshake FSM with registered outputs; pulses default low each cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_sel       <= '0;
      r_rr_ptr    <= '0;
      r_timer     <= '0;
      r_last      <= 1'b0;
      req_ready   <= '0;
      grant       <= '0;
      tx_wr_en    <= 1'b0;
      tx_din      <= '0;
      active      <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      tx_wr_en    <= 1'b0;
      req_ready   <= '0;
      timeout_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_sel   <= w_sel;
            grant   <= f_onehot(w_sel);
            active  <= 1'b1;
            r_state <= S_SEND;
          end
        end
        S_SEND: begin
          // An owner that stalls mid-packet keeps the grant indefinitely.
          if (req_valid[r_sel]) begin
            tx_wr_en  <= 1'b1;
            tx_din    <= req_data[8*r_sel +: 8];
            req_ready <= f_onehot(r_sel);
            r_last    <= req_last[r_sel];
            r_timer   <= '0;
            r_state   <= S_WAIT_HI;
          end
        end
        S_WAIT_HI: begin
          // uart_tx raises busy a couple of cycles after wrEn; the timer covers that latency.
          if (tx_busy) begin
            r_state <= S_WAIT_LO;
          end else if (r_timer == TMR_LAST) begin
            timeout_err <= 1'b1;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_WAIT_LO: begin
          r_state <= S_WAIT_LO;
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_byte_done) begin
        if (r_last) begin
          grant    <= '0;
          active   <= 1'b0;
          r_rr_ptr <= w_next_ptr;
          r_state  <= S_IDLE;
        end else begin
          r_state  <= S_SEND;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized packet sources, a behavioural uart_tx busy
// model and a round-robin packet-order reference model.
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int BT = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NR-1:0]     req_valid;
  logic [8*NR-1:0]   req_data;
  logic [NR-1:0]     req_last;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     grant;
  logic              tx_wr_en;
  logic [7:0]        tx_din;
  logic              tx_busy;
  logic              active;
  logic              timeout_err;

  uart_tx_arbiter #(.NUM_REQ(NR), .BUSY_TIMEOUT(BT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .grant(grant),
    .tx_wr_en(tx_wr_en), .tx_din(tx_din), .tx_busy(tx_busy),
    .active(active), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // requester driver queues: {last,data} plus idle cycles before presenting the byte
  logic [8:0] pq [NR][$];
  int         pg [NR][$];
  // reference model: packets still to be transmitted, and its round-robin pointer
  logic [8:0] mq [NR][$];
  int         m_ptr = 0;
  int         exp_idx[$];
  logic [7:0] exp_dat[$];

  // observations
  int            obs_idx[$];
  logic [7:0]    obs_dat[$];
  logic [NR-1:0] ghist[$];
  int            rdy_cnt [NR];
  int            to_cnt, to_cyc, wr_cyc, cyc;
  bit            mon_en    = 0;
  bit            busy_tie0 = 0;
  logic          prev_wr;
  logic [NR-1:0] prev_grant;

  function automatic int g2i(input logic [NR-1:0] g);
    int r = -1;
    for (int i = 0; i < NR; i++) if (g[i]) r = i;
    return r;
  endfunction

  function automatic bit all_empty();
    bit e = 1;
    for (int i = 0; i < NR; i++) if (pq[i].size() != 0) e = 0;
    return e;
  endfunction

  // requester drivers: present the front byte, pop it on req_ready
  initial begin
    req_valid = '0; req_data = '0; req_last = '0;
    forever begin
      @(posedge clk); #2;
      for (int i = 0; i < NR; i++) begin
        if (req_ready[i] && pq[i].size() > 0) begin
          void'(pq[i].pop_front());
          void'(pg[i].pop_front());
        end
        if (pq[i].size() > 0 && pg[i][0] > 0) begin
          pg[i][0] = pg[i][0] - 1;
          req_valid[i] = 1'b0;
        end else if (pq[i].size() > 0) begin
          req_valid[i] = 1'b1;
          req_data[8*i +: 8] = pq[i][0][7:0];
          req_last[i] = pq[i][0][8];
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
  end

  // uart_tx busy model: busy rises two cycles after the wrEn edge, lasts 3..10 cycles
  initial begin
    int dly = 0;
    int blen = 0;
    tx_busy = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (tx_busy) begin
        blen--;
        if (blen == 0) tx_busy = 1'b0;
      end else if (dly > 0) begin
        dly--;
        if (dly == 0) begin tx_busy = 1'b1; blen = $urandom_range(3, 10); end
      end else if (tx_wr_en === 1'b1 && !busy_tie0) begin
        dly = 2;
      end
    end
  end

  // monitor: record traffic and check per-cycle handshake rules
  initial begin
    cyc = 0; prev_wr = 1'b0; prev_grant = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (mon_en) begin
        total++;
        if (tx_wr_en && prev_wr) begin
          bad++; $display("FAIL wr_consecutive: tx_wr_en high two cycles running at cyc %0d, required single pulses", cyc);
        end
        total++;
        if (req_ready !== (tx_wr_en ? grant : {NR{1'b0}})) begin
          bad++; $display("FAIL ready_rule: req_ready=%b tx_wr_en=%b grant=%b at cyc %0d", req_ready, tx_wr_en, grant, cyc);
        end
        total++;
        if (!$onehot0(grant) || active !== (grant != '0)) begin
          bad++; $display("FAIL grant_active: grant=%b active=%b at cyc %0d, required one-hot grant iff active", grant, active, cyc);
        end
        if (tx_wr_en) begin
          obs_idx.push_back(g2i(grant));
          obs_dat.push_back(tx_din);
          wr_cyc = cyc;
        end
        for (int i = 0; i < NR; i++) if (req_ready[i]) rdy_cnt[i]++;
        if (grant !== prev_grant) ghist.push_back(grant);
        if (timeout_err) begin to_cnt++; to_cyc = cyc; end
        prev_wr = tx_wr_en;
        prev_grant = grant;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic add_byte(input int r, input logic [7:0] d, input logic last, input int gap);
    pq[r].push_back({last, d});
    pg[r].push_back(gap);
    mq[r].push_back({last, d});
  endtask

  // Round-robin over requesters holding complete packets; each winner sends its whole packet.
  task automatic model_run();
    bit more = 1;
    while (more) begin
      int r = -1;
      for (int k = 0; k < NR; k++) begin
        int c = (m_ptr + k) % NR;
        if (r < 0 && mq[c].size() > 0) r = c;
      end
      if (r < 0) begin
        more = 0;
      end else begin
        logic [8:0] e;
        do begin
          e = mq[r].pop_front();
          exp_idx.push_back(r);
          exp_dat.push_back(e[7:0]);
        end while (!e[8]);
        m_ptr = (r + 1) % NR;
      end
    end
  endtask

  task automatic clear_obs();
    obs_idx.delete(); obs_dat.delete(); exp_idx.delete(); exp_dat.delete(); ghist.delete();
    for (int i = 0; i < NR; i++) rdy_cnt[i] = 0;
    to_cnt = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < NR; i++) begin pq[i].delete(); pg[i].delete(); mq[i].delete(); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_ptr = 0;
  endtask

  task automatic wait_idle(input int budget, output bit expired);
    int n = 0;
    expired = 0;
    @(negedge clk);
    while (!(all_empty() && active === 1'b0 && tx_busy === 1'b0)) begin
      @(negedge clk);
      n++;
      if (n >= budget) begin expired = 1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (grant !== '0) begin bad++; $display("FAIL reset_grant: got %b want 0", grant); end
    total++; if (req_ready !== '0) begin bad++; $display("FAIL reset_ready: got %b want 0", req_ready); end
    total++; if (tx_wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en: got %b want 0", tx_wr_en); end
    total++; if (tx_din !== 8'h00) begin bad++; $display("FAIL reset_din: got %h want 00", tx_din); end
    total++; if (active !== 1'b0) begin bad++; $display("FAIL reset_active: got %b want 0", active); end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL reset_timeout: got %b want 0", timeout_err); end
    rst = 1'b0;
    m_ptr = 0;
    mon_en = 1;
  endtask

  task automatic test_single();
    bit to;
    clear_obs();
    add_byte(0, 8'h41, 1'b0, 0);
    add_byte(0, 8'h42, 1'b0, 0);
    add_byte(0, 8'h43, 1'b1, 0);
    model_run();
    wait_idle(500, to);
    total++; if (to) begin bad++; $display("FAIL single_wait: idle not reached, got busy want idle"); end
    total++; if (obs_dat.size() != 3) begin bad++; $display("FAIL single_count: got %0d bytes want 3", obs_dat.size()); end
    else for (int k = 0; k < 3; k++) begin
      total++;
      if (obs_idx[k] !== exp_idx[k] || obs_dat[k] !== exp_dat[k])
        begin bad++; $display("FAIL single_byte%0d: got req%0d %h want req%0d %h", k, obs_idx[k], obs_dat[k], exp_idx[k], exp_dat[k]); end
    end
    total++; if (rdy_cnt[0] != 3) begin bad++; $display("FAIL single_ready: got %0d pulses want 3", rdy_cnt[0]); end
    total++; if (ghist.size() != 2 || ghist[0] !== 4'b0001 || ghist[1] !== 4'b0000)
      begin bad++; $display("FAIL single_grant: got %0d grant changes want 0001 then 0000", ghist.size()); end
    // pointer now past requester 0: a simultaneous req0/req1 pair must serve req1 first
    clear_obs();
    add_byte(0, 8'h5A, 1'b1, 0);
    add_byte(1, 8'hA5, 1'b1, 0);
    model_run();
    wait_idle(500, to);
    total++; if (to) begin bad++; $display("FAIL ptr_wait: idle not reached"); end
    total++; if (obs_idx.size() != 2 || obs_idx[0] !== exp_idx[0] || obs_idx[1] !== exp_idx[1])
      begin bad++; $display("FAIL ptr_order: got %0d bytes first req%0d want req%0d", obs_idx.size(), (obs_idx.size() > 0) ? obs_idx[0] : -1, exp_idx[0]); end
  endtask

  task automatic test_contention();
    bit to;
    do_reset();
    clear_obs();
    add_byte(1, 8'h11, 1'b0, 0); add_byte(1, 8'h12, 1'b1, 0);
    add_byte(3, 8'h31, 1'b0, 0); add_byte(3, 8'h32, 1'b1, 0);
    model_run();
    wait_idle(500, to);
    total++; if (to) begin bad++; $display("FAIL cont_wait: idle not reached"); end
    total++; if (obs_idx.size() != exp_idx.size()) begin bad++; $display("FAIL cont_count: got %0d want %0d", obs_idx.size(), exp_idx.size()); end
    else for (int k = 0; k < exp_idx.size(); k++) begin
      total++;
      if (obs_idx[k] !== exp_idx[k] || obs_dat[k] !== exp_dat[k])
        begin bad++; $display("FAIL cont_byte%0d: got req%0d %h want req%0d %h", k, obs_idx[k], obs_dat[k], exp_idx[k], exp_dat[k]); end
    end
    total++;
    if (ghist.size() != 4 || ghist[0] !== 4'b0010 || ghist[1] !== 4'b0000 || ghist[2] !== 4'b1000 || ghist[3] !== 4'b0000)
      begin bad++; $display("FAIL cont_grant: got %0d changes want 0010,0000,1000,0000", ghist.size()); end
  endtask

  task automatic test_wrap();
    bit to;
    do_reset();
    clear_obs();
    for (int i = 0; i < NR; i++) add_byte(i, 8'($urandom()), 1'b1, 0);
    add_byte(0, 8'($urandom()), 1'b1, 0);
    add_byte(1, 8'($urandom()), 1'b1, 0);
    model_run();
    wait_idle(1000, to);
    total++; if (to) begin bad++; $display("FAIL wrap_wait: idle not reached"); end
    total++; if (obs_idx.size() != 6) begin bad++; $display("FAIL wrap_count: got %0d want 6", obs_idx.size()); end
    else for (int k = 0; k < 6; k++) begin
      total++;
      if (obs_idx[k] !== exp_idx[k] || obs_dat[k] !== exp_dat[k])
        begin bad++; $display("FAIL wrap_byte%0d: got req%0d %h want req%0d %h", k, obs_idx[k], obs_dat[k], exp_idx[k], exp_dat[k]); end
    end
  endtask

  task automatic test_stall();
    bit to;
    int n, wr0, r0, gbad;
    do_reset();
    clear_obs();
    add_byte(2, 8'($urandom()), 1'b0, 0);
    add_byte(2, 8'($urandom()), 1'b0, 50);
    add_byte(2, 8'($urandom()), 1'b1, 0);
    model_run();
    n = 0;
    while (grant !== 4'b0100 && n < 100) begin @(negedge clk); n++; end
    total++; if (grant !== 4'b0100) begin bad++; $display("FAIL stall_grant0: got %b want 0100", grant); end
    add_byte(0, 8'($urandom()), 1'b1, 0);
    model_run();
    n = 0;
    while (rdy_cnt[2] < 1 && n < 100) begin @(negedge clk); n++; end
    wr0 = obs_idx.size(); r0 = rdy_cnt[0]; gbad = 0;
    repeat (40) begin @(negedge clk); if (grant !== 4'b0100) gbad++; end
    total++; if (obs_idx.size() != wr0) begin bad++; $display("FAIL stall_wr: got %0d writes during stall want 0", obs_idx.size() - wr0); end
    total++; if (rdy_cnt[0] != r0) begin bad++; $display("FAIL stall_ready0: got %0d req0 ready pulses want 0", rdy_cnt[0] - r0); end
    total++; if (gbad != 0) begin bad++; $display("FAIL stall_hold: grant left 0100 on %0d cycles want 0", gbad); end
    wait_idle(1000, to);
    total++; if (to) begin bad++; $display("FAIL stall_wait: idle not reached"); end
    total++; if (obs_idx.size() != exp_idx.size()) begin bad++; $display("FAIL stall_count: got %0d want %0d", obs_idx.size(), exp_idx.size()); end
    else for (int k = 0; k < exp_idx.size(); k++) begin
      total++;
      if (obs_idx[k] !== exp_idx[k] || obs_dat[k] !== exp_dat[k])
        begin bad++; $display("FAIL stall_byte%0d: got req%0d %h want req%0d %h", k, obs_idx[k], obs_dat[k], exp_idx[k], exp_dat[k]); end
    end
  endtask

  task automatic test_timeout();
    bit to;
    do_reset();
    clear_obs();
    busy_tie0 = 1;
    add_byte(0, 8'h7E, 1'b1, 0);
    model_run();
    wait_idle(200, to);
    total++; if (to) begin bad++; $display("FAIL tmo_wait: idle not reached"); end
    total++; if (to_cnt != 1) begin bad++; $display("FAIL tmo_count: got %0d pulses want 1", to_cnt); end
    total++; if (to_cyc - wr_cyc != BT) begin bad++; $display("FAIL tmo_latency: got %0d cycles want %0d", to_cyc - wr_cyc, BT); end
    total++; if (ghist.size() != 2 || ghist[1] !== 4'b0000) begin bad++; $display("FAIL tmo_grant: got %0d changes want grant back to 0000", ghist.size()); end
    total++; if (obs_dat.size() != 1 || obs_dat[0] !== exp_dat[0]) begin bad++; $display("FAIL tmo_byte: got %0d bytes want 1 of %h", obs_dat.size(), exp_dat[0]); end
    busy_tie0 = 0;
    clear_obs();
    add_byte(1, 8'($urandom()), 1'b0, 0);
    add_byte(1, 8'($urandom()), 1'b1, 0);
    model_run();
    wait_idle(500, to);
    total++; if (to) begin bad++; $display("FAIL tmo_next_wait: idle not reached"); end
    total++; if (obs_idx.size() != 2 || obs_idx[1] !== exp_idx[1] || obs_dat[0] !== exp_dat[0] || obs_dat[1] !== exp_dat[1])
      begin bad++; $display("FAIL tmo_next: got %0d bytes want 2 from req%0d", obs_idx.size(), exp_idx[0]); end
    total++; if (to_cnt != 0) begin bad++; $display("FAIL tmo_spurious: got %0d pulses want 0", to_cnt); end
  endtask

  task automatic test_reset_mid();
    bit to;
    int n, wr0;
    do_reset();
    clear_obs();
    for (int k = 0; k < 4; k++) add_byte(0, 8'($urandom()), (k == 3), 0);
    n = 0;
    while (obs_idx.size() < 2 && n < 300) begin @(negedge clk); n++; end
    total++; if (obs_idx.size() != 2) begin bad++; $display("FAIL rmid_reach: got %0d writes want 2", obs_idx.size()); end
    rst = 1'b1;
    for (int i = 0; i < NR; i++) begin pq[i].delete(); pg[i].delete(); mq[i].delete(); end
    @(negedge clk);
    rst = 1'b0;
    m_ptr = 0;
    total++; if ({grant, req_ready, tx_wr_en, tx_din, active, timeout_err} !== '0)
      begin bad++; $display("FAIL rmid_zero: got grant=%b ready=%b wr=%b din=%h act=%b to=%b want all 0", grant, req_ready, tx_wr_en, tx_din, active, timeout_err); end
    wr0 = obs_idx.size();
    repeat (30) @(negedge clk);
    total++; if (obs_idx.size() != wr0) begin bad++; $display("FAIL rmid_nowr: got %0d writes after reset want 0", obs_idx.size() - wr0); end
    clear_obs();
    add_byte(1, 8'($urandom()), 1'b1, 0);
    add_byte(0, 8'($urandom()), 1'b0, 0);
    add_byte(0, 8'($urandom()), 1'b1, 0);
    model_run();
    wait_idle(800, to);
    total++; if (to) begin bad++; $display("FAIL rmid_wait: idle not reached"); end
    total++; if (obs_idx.size() != exp_idx.size()) begin bad++; $display("FAIL rmid_count: got %0d want %0d", obs_idx.size(), exp_idx.size()); end
    else for (int k = 0; k < exp_idx.size(); k++) begin
      total++;
      if (obs_idx[k] !== exp_idx[k] || obs_dat[k] !== exp_dat[k])
        begin bad++; $display("FAIL rmid_byte%0d: got req%0d %h want req%0d %h", k, obs_idx[k], obs_dat[k], exp_idx[k], exp_dat[k]); end
    end
  endtask

  task automatic test_random();
    bit to;
    int len;
    clear_obs();
    for (int i = 0; i < NR; i++) begin
      for (int p = 0; p < int'($urandom_range(1, 3)); p++) begin
        len = $urandom_range(1, 4);
        for (int k = 0; k < len; k++)
          add_byte(i, 8'($urandom()), (k == len - 1), (k == 0) ? 0 : int'($urandom_range(0, 3)));
      end
    end
    model_run();
    wait_idle(8000, to);
    total++; if (to) begin bad++; $display("FAIL rand_wait: idle not reached"); end
    total++; if (obs_idx.size() != exp_idx.size()) begin bad++; $display("FAIL rand_count: got %0d want %0d", obs_idx.size(), exp_idx.size()); end
    else for (int k = 0; k < exp_idx.size(); k++) begin
      total++;
      if (obs_idx[k] !== exp_idx[k] || obs_dat[k] !== exp_dat[k])
        begin bad++; $display("FAIL rand_byte%0d: got req%0d %h want req%0d %h", k, obs_idx[k], obs_dat[k], exp_idx[k], exp_dat[k]); end
    end
    total++; if (to_cnt != 0) begin bad++; $display("FAIL rand_timeout: got %0d pulses want 0", to_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_wrap();
    test_stall();
    test_timeout();
    test_reset_mid();
    test_random();
    test_random();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
